// File: rtl/rx_align_pkg.sv
// Shared types and constants for the RX word-alignment controller.
package rx_align_pkg;

    localparam int SYM_BITS = 10;

    // K28.5 comma in both running disparities, first-received bit at [9]
    localparam logic [SYM_BITS-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_BITS-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module rx_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/rx_align_ctrl.sv
// Comma hunt / lock controller for the serial RX path, with RX FIFO write gating.
// Optional lock-loss statistics counter enabled by defining RX_ALIGN_STATS_EN.
module rx_align_ctrl
    import rx_align_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 4,
    parameter int OVF_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                serin,
    output logic [SYM_BITS-1:0] sym_out,
    output logic                sym_valid,
    input  logic                dec_valid,
    input  logic                dec_err,
    input  logic                dec_kout,
    input  logic                fifo_full,
    output logic                fifo_wen,
    output logic                locked,
    output logic [OVF_W-1:0]    ovf_cnt,
    output logic [7:0]          loss_cnt
);

    localparam int CC_W = $clog2(LOCK_COUNT + 1);
    localparam int EC_W = $clog2(ERR_LIMIT + 1);
    localparam logic [3:0] LAST_PHASE = 4'(SYM_BITS - 1);

    logic [SYM_BITS-1:0] sr_reg;
    logic [SYM_BITS-1:0] sym_reg;
    logic [3:0]          phase_reg, phase_next;
    logic [CC_W-1:0]     comma_cnt_reg, comma_cnt_next;
    align_state_t        state_reg, state_next;
    logic                sym_valid_reg;
    logic                locked_reg;
    logic [EC_W-1:0]     err_cnt;
    logic                comma;
    logic                at_boundary;
    logic                emit;
    logic                err_in;
    logic                err_hit;

    assign comma       = (sr_reg == K28_5_RDN) || (sr_reg == K28_5_RDP);
    assign at_boundary = (phase_reg == LAST_PHASE);
    assign err_in      = dec_valid && dec_err;
    // The error that would make err_cnt reach ERR_LIMIT drops lock directly
    assign err_hit     = (state_reg == LOCKED) && err_in && (err_cnt == EC_W'(ERR_LIMIT - 1));

    always_comb begin
        state_next     = state_reg;
        phase_next     = at_boundary ? 4'd0 : phase_reg + 4'd1;
        comma_cnt_next = comma_cnt_reg;
        emit           = 1'b0;
        case (state_reg)
            HUNT: begin
                if (comma) begin
                    phase_next     = 4'd0;
                    comma_cnt_next = CC_W'(1);
                    emit           = 1'b1;
                    state_next     = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                // An error in the same cycle as a boundary wins over the symbol
                if (err_in) begin
                    state_next     = HUNT;
                    comma_cnt_next = '0;
                end else if (comma) begin
                    phase_next = 4'd0;
                    emit       = 1'b1;
                    if (at_boundary) begin
                        comma_cnt_next = comma_cnt_reg + 1'b1;
                        if (comma_cnt_reg == CC_W'(LOCK_COUNT - 1)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        comma_cnt_next = CC_W'(1);
                    end
                end else if (at_boundary) begin
                    emit = 1'b1;
                end
            end
            LOCKED: begin
                emit = at_boundary && !err_hit;
                if (err_hit) begin
                    state_next     = HUNT;
                    comma_cnt_next = '0;
                end
            end
            default: begin
                state_next     = HUNT;
                comma_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg        <= '0;
            sym_reg       <= '0;
            phase_reg     <= '0;
            comma_cnt_reg <= '0;
            state_reg     <= HUNT;
            sym_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            sr_reg        <= {sr_reg[SYM_BITS-2:0], serin};
            phase_reg     <= phase_next;
            comma_cnt_reg <= comma_cnt_next;
            state_reg     <= state_next;
            sym_valid_reg <= emit;
            locked_reg    <= (state_next == LOCKED);
            if (emit) begin
                sym_reg <= sr_reg;
            end
        end
    end

    rx_sat_counter #(.W(EC_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_reg == LOCKED) && err_in),
        .clr   ((state_reg != LOCKED) || (dec_valid && !dec_err) || err_hit),
        .cnt   (err_cnt)
    );

    rx_sat_counter #(.W(OVF_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (locked_reg && dec_valid && !dec_kout && fifo_full),
        .clr   (1'b0),
        .cnt   (ovf_cnt)
    );

`ifdef RX_ALIGN_STATS_EN
    rx_sat_counter #(.W(8)) u_loss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_hit),
        .clr   (1'b0),
        .cnt   (loss_cnt)
    );
`else
    assign loss_cnt = '0;
`endif

    assign fifo_wen  = locked_reg && dec_valid && !dec_kout && !fifo_full;
    assign sym_out   = sym_reg;
    assign sym_valid = sym_valid_reg;
    assign locked    = locked_reg;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Scoreboard bench for rx_align_ctrl with a small behavioural decoder/FIFO model.
module tb_rx_align_ctrl;
    import rx_align_pkg::*;

    localparam int ERR_LIMIT = 4;
    localparam int OVF_MAX   = 255;
`ifdef RX_ALIGN_STATS_EN
    localparam int EXP_LOSS = 1;
`else
    localparam int EXP_LOSS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serin = 1'b0;
    logic       dec_valid = 1'b0;
    logic       dec_err = 1'b0;
    logic       dec_kout = 1'b0;
    logic       fifo_full = 1'b0;
    logic [9:0] sym_out;
    logic       sym_valid;
    logic       fifo_wen;
    logic       locked;
    logic [7:0] ovf_cnt;
    logic [7:0] loss_cnt;

    rx_align_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serin     (serin),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .dec_valid (dec_valid),
        .dec_err   (dec_err),
        .dec_kout  (dec_kout),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .locked    (locked),
        .ovf_cnt   (ovf_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        int         cyc;
        int         lock;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         err_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         strict = 1'b0;
    bit         chk_wen = 1'b0;
    bit         chk_err = 1'b0;
    int         run = 0;
    int         full_left = 0;
    int         kcnt = 0;
    int         exp_ovf = 0;
    bit         pend = 1'b0;
    bit         pend_exp = 1'b0;
    bit         pv[3], pe[3], pk[3];
    logic [9:0] dtab[4] = '{10'b1010101010, 10'b0101010101, 10'b1100110011, 10'b0011001100};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Symbol scoreboard: each expected symbol carries its arrival cycle
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                check("sym_valid", sym_valid, 1'b1);
                if (sym_valid) begin
                    check("sym_out", sym_out, mon_e.sym);
                    $display("sym %b at cycle %0d locked=%0b", sym_out, cyc, locked);
                    if (mon_e.lock >= 0) check("locked_at_sym", locked, mon_e.lock[0]);
                end
            end else if (sym_valid && strict) begin
                check("sym_unexpected", sym_valid, 1'b0);
            end
        end
    end

    // Decoder model: fixed latency, errors from err_q, kout on commas
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0; pe[i] = 1'b0; pk[i] = 1'b0;
            end
            dec_valid = 1'b0; dec_err = 1'b0; dec_kout = 1'b0; fifo_full = 1'b0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("locked_after_dec", locked, pend_exp);
                pend = 1'b0;
            end
            for (int i = 2; i > 0; i--) begin
                pv[i] = pv[i-1]; pe[i] = pe[i-1]; pk[i] = pk[i-1];
            end
            pv[0] = sym_valid;
            pe[0] = 1'b0;
            if (sym_valid && err_q.size() > 0) pe[0] = err_q.pop_front();
            pk[0] = sym_valid && ((sym_out == K28_5_RDN) || (sym_out == K28_5_RDP));
            dec_valid = pv[2];
            dec_err   = pv[2] && pe[2];
            dec_kout  = pv[2] && pk[2];
            fifo_full = 1'b0;
            if (dec_valid) begin
                if (dec_kout) begin
                    fifo_full = (kcnt % 2) == 1;
                    kcnt++;
                end else if (full_left > 0) begin
                    fifo_full = 1'b1;
                    full_left--;
                    if (exp_ovf < OVF_MAX) exp_ovf++;
                end
                if (chk_err) begin
                    run      = dec_err ? run + 1 : 0;
                    pend     = 1'b1;
                    pend_exp = (run < ERR_LIMIT);
                    if (run >= ERR_LIMIT) chk_err = 1'b0;
                end
                if (chk_wen) begin
                    #1;
                    check("fifo_wen", fifo_wen, !dec_kout && !fifo_full);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        serin = b;
    endtask

    task automatic send_sym(input logic [9:0] s, input bit push, input int lk);
        exp_t e;
        for (int i = 9; i >= 0; i--) send_bit(s[i]);
        if (push) begin
            e.sym = s; e.cyc = cyc + 2; e.lock = lk;
            exp_q.push_back(e);
        end
    endtask

    task automatic acquire();
        for (int r = 0; r < 3; r++) begin
            send_sym(K28_5_RDN, 1'b1, (r == 2) ? 1 : 0);
            send_sym(dtab[r], 1'b1, (r == 2) ? 1 : 0);
        end
    endtask

    initial begin
        logic b0, b1, b;
        repeat (3) @(negedge clk);
        check("rst_sym_valid", sym_valid, 1'b0);
        check("rst_sym_out", sym_out, 10'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_ovf", ovf_cnt, 8'd0);
        check("rst_loss", loss_cnt, 8'd0);
        check("rst_fifo_wen", fifo_wen, 1'b0);
        rst_n  = 1'b1;
        strict = 1'b1;

        // Acquisition: comma-free random preamble (runs of at most 2)
        b0 = 1'b0; b1 = 1'b1;
        for (int i = 0; i < 37; i++) begin
            b = 1'($urandom_range(0, 1));
            if (b == b0 && b0 == b1) b = ~b;
            send_bit(b);
            b1 = b0; b0 = b;
        end
        acquire();

        // FIFO full across 5 data symbols
        chk_wen   = 1'b1;
        full_left = 5;
        for (int i = 0; i < 10; i++) send_sym(dtab[i % 4], 1'b1, 1);
        check("ovf_after_5", ovf_cnt, exp_ovf);
        check("ovf_is_5", ovf_cnt, 8'd5);

        // K filtering with fifo_full alternating on commas
        for (int i = 0; i < 3; i++) begin
            send_sym(K28_5_RDN, 1'b1, 1);
            send_sym(dtab[i], 1'b1, 1);
        end
        send_sym(dtab[3], 1'b1, 1);
        check("ovf_after_k", ovf_cnt, 8'd5);
        chk_wen = 1'b0;

        // Error tolerance: 3 errors, 1 good, 3 errors
        run = 0;
        chk_err = 1'b1;
        err_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) send_sym(dtab[i % 4], 1'b1, 1);
        chk_err = 1'b0;
        for (int i = 0; i < 3; i++) send_sym(dtab[i], 1'b1, 1);

        // Bit slip while locked, then 4 decoder errors
        strict = 1'b0;
        send_bit(~dtab[2][0]);
        run = 0;
        chk_err = 1'b1;
        for (int i = 0; i < 4; i++) err_q.push_back(1'b1);
        for (int i = 0; i < 10; i++) begin
            send_sym(dtab[0], 1'b0, -1);
            if (!locked) break;
        end
        check("slip_drop", locked, 1'b0);
        strict = 1'b1;
        acquire();
        check("loss_cnt", loss_cnt, EXP_LOSS);

        // 300 drops saturate the overflow counter
        chk_wen   = 1'b1;
        full_left = 300;
        for (int i = 0; i < 305; i++) send_sym(dtab[i % 4], 1'b1, 1);
        check("ovf_sat", ovf_cnt, exp_ovf);
        check("ovf_is_max", ovf_cnt, 8'd255);
        chk_wen = 1'b0;

        // Reset mid-lock: async clear between clock edges
        send_sym(dtab[1], 1'b0, -1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        err_q.delete();
        #1;
        check("arst_locked", locked, 1'b0);
        check("arst_sym_valid", sym_valid, 1'b0);
        check("arst_ovf", ovf_cnt, 8'd0);
        check("arst_fifo_wen", fifo_wen, 1'b0);
        check("arst_loss", loss_cnt, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_sym(dtab[i % 4], 1'b0, -1);
        check("post_rst_locked", locked, 1'b0);
        check("sym_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
